// File: rtl/md_unit_pkg.sv
// Shared encodings, default cycle counts and FSM states for the EX-stage multiply/divide unit.
package md_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;
endpackage

// File: rtl/md_unit_if.sv
// Issue/result bundle between EX and the multiply/divide unit; busy tells the hazard unit to hold HI/LO users.
interface md_unit_if;
  logic        start;
  logic [2:0]  mdOp;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [31:0] pcIn;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, mdOp, srcA, srcB, pcIn, input busy, hi, lo);
  modport slave  (input start, mdOp, srcA, srcB, pcIn, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// HI/LO owner: result computed at issue, committed after MULT_CYCLES/DIV_CYCLES busy cycles; MTHI/MTLO take one edge.
// Issue while busy is dropped (hazard unit prevents it). MD_TRACE_EN prints commits; MD_ISSUE_ASSERT flags issue-while-busy.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);

  md_state_e   r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_tmp_hi, r_tmp_lo;
  logic        r_skip;

  logic        w_issue, w_arith, w_is_div, w_div0, w_commit;
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_neg_a, w_neg_b;
  logic [31:0] w_abs_a, w_abs_b, w_sdiv_by, w_udiv_by;
  logic [31:0] w_q_mag, w_r_mag, w_squo, w_srem, w_uquo, w_urem;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_issue  = (r_state == IDLE) && md.start;
  assign w_arith  = w_issue && (md.mdOp inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
  assign w_is_div = (md.mdOp == MD_DIV) || (md.mdOp == MD_DIVU);
  assign w_div0   = (md.srcB == 32'd0);
  assign w_commit = (r_state == BUSY) && (r_cnt == 4'd1);

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{md.srcA[31]}}, md.srcA} * {{32{md.srcB[31]}}, md.srcB};
  assign w_prod_u = {32'd0, md.srcA} * {32'd0, md.srcB};

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
  assign w_neg_a   = md.srcA[31];
  assign w_neg_b   = md.srcB[31];
  assign w_abs_a   = w_neg_a ? -md.srcA : md.srcA;
  assign w_abs_b   = w_neg_b ? -md.srcB : md.srcB;
  assign w_sdiv_by = w_div0 ? 32'd1 : w_abs_b;
  assign w_udiv_by = w_div0 ? 32'd1 : md.srcB;
  assign w_q_mag   = w_abs_a / w_sdiv_by;
  assign w_r_mag   = w_abs_a % w_sdiv_by;
  assign w_squo    = (w_neg_a ^ w_neg_b) ? -w_q_mag : w_q_mag;
  assign w_srem    = w_neg_a ? -w_r_mag : w_r_mag;
  assign w_uquo    = md.srcA / w_udiv_by;
  assign w_urem    = md.srcA % w_udiv_by;

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    case (md.mdOp)
      MD_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      MD_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      MD_DIV:   begin w_res_hi = w_srem; w_res_lo = w_squo; end
      MD_DIVU:  begin w_res_hi = w_urem; w_res_lo = w_uquo; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_arith) w_next = BUSY;
      BUSY:    if (r_cnt == 4'd1) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
      r_skip   <= 1'b0;
    end else begin
      if (w_arith) begin
        r_tmp_hi <= w_res_hi;
        r_tmp_lo <= w_res_lo;
        r_skip   <= w_is_div && w_div0;
        r_cnt    <= w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_commit && !r_skip) begin
          r_hi <= r_tmp_hi;
          r_lo <= r_tmp_lo;
        end
      end
      if (w_issue && (md.mdOp == MD_MTHI)) r_hi <= md.srcA;
      if (w_issue && (md.mdOp == MD_MTLO)) r_lo <= md.srcA;
    end
  end

`ifdef MD_TRACE_EN
  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else begin
      if (w_arith) r_pc <= md.pcIn;
      if (w_issue && (md.mdOp == MD_MTHI)) $display("@%h: $hi <= %h", md.pcIn, md.srcA);
      if (w_issue && (md.mdOp == MD_MTLO)) $display("@%h: $lo <= %h", md.pcIn, md.srcA);
      if (w_commit && !r_skip) begin
        $display("@%h: $hi <= %h", r_pc, r_tmp_hi);
        $display("@%h: $lo <= %h", r_pc, r_tmp_lo);
      end
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^md.pcIn;
`endif

`ifdef MD_ISSUE_ASSERT
  always_ff @(posedge clk) begin
    if (reset && (r_state == BUSY)) assert (!md.start) else $error("md_unit: start while busy");
  end
`endif

  assign md.busy = (r_state == BUSY);
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: arithmetic results, busy duration, MT ops, ignored issue and async reset abort.
module tb_md_unit;
  import md_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n;

  md_unit_if u_if ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .md    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns at the negedge after the issue edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.mdOp  = op;
    u_if.srcA  = a;
    u_if.srcB  = b;
    u_if.pcIn  = u_if.pcIn + 32'd4;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.mdOp  = 3'd7;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (u_if.busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    issue(op, a, b);
    wait_idle(c);
    chk({tag, " busy cycles"}, 32'(c), 32'(cyc));
    chk({tag, " hi"}, u_if.hi, exp_hi);
    chk({tag, " lo"}, u_if.lo, exp_lo);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    u_if.start = 1'b0;
    u_if.mdOp  = 3'd7;
    u_if.srcA  = '0;
    u_if.srcB  = '0;
    u_if.pcIn  = 32'h0040_0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", {31'd0, u_if.busy}, 32'd0);
    chk("reset hi", u_if.hi, 32'd0);
    chk("reset lo", u_if.lo, 32'd0);

    run_op("mult -1*2", MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult min*min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);
    run_op("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", MD_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu 100/7", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    issue(MD_MTHI, 32'h0000_1234, 32'h0);
    chk("mthi busy", {31'd0, u_if.busy}, 32'd0);
    chk("mthi hi", u_if.hi, 32'h0000_1234);
    issue(MD_MTLO, 32'h0000_5678, 32'h0);
    chk("mtlo busy", {31'd0, u_if.busy}, 32'd0);
    chk("mtlo lo", u_if.lo, 32'h0000_5678);
    chk("mtlo hi kept", u_if.hi, 32'h0000_1234);
    run_op("divu by 0", MD_DIVU, 32'h0000_0064, 32'h0, 10, 32'h0000_1234, 32'h0000_5678);
    run_op("div by 0", MD_DIV, 32'hFFFF_FF00, 32'h0, 10, 32'h0000_1234, 32'h0000_5678);
    run_op("div ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    // Second issue during busy plus operand churn must not disturb the first op.
    issue(MD_MULT, 32'd3, 32'd4);
    u_if.start = 1'b1;
    u_if.mdOp  = MD_MULTU;
    u_if.srcA  = 32'hFFFF_FFFF;
    u_if.srcB  = 32'hFFFF_FFFF;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.mdOp  = 3'd7;
    u_if.srcA  = 32'h55;
    u_if.srcB  = 32'h66;
    wait_idle(n);
    chk("busy-issue cycles", 32'(n + 1), 32'd5);
    chk("busy-issue hi", u_if.hi, 32'd0);
    chk("busy-issue lo", u_if.lo, 32'd12);
    repeat (6) @(negedge clk);
    chk("busy-issue no restart", {31'd0, u_if.busy}, 32'd0);
    chk("busy-issue lo kept", u_if.lo, 32'd12);

    issue(MD_MTHI, 32'h0000_AAAA, 32'h0);
    issue(MD_DIV, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, u_if.busy}, 32'd0);
    chk("abort hi", u_if.hi, 32'd0);
    chk("abort lo", u_if.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("post-abort busy", {31'd0, u_if.busy}, 32'd0);
    chk("post-abort hi", u_if.hi, 32'd0);
    chk("post-abort lo", u_if.lo, 32'd0);

    run_op("post-abort divu", MD_DIVU, 32'd100, 32'd3, 10, 32'd1, 32'd33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit owning the HI/LO registers.
- Sits in EX, directly downstream of the register file: consumes the two register read operands (after forwarding) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Exposes HI/LO for MFHI/MFLO.
- Drives busy so the hazard unit stalls any HI/LO-touching instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU; legal range 1..15.
- DIV_CYCLES, 10, busy duration for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  issue strobe for the op on mdOp, one cycle.
- mdOp  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op.
- srcA  input  32  rs operand.
- srcB  input  32  rt operand.
- pcIn  input  32  PC of the issuing instruction; used by the trace feature only.
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, hi=0, lo=0, counter=0.
  - Any in-flight operation is aborted and its result discarded.
- States: IDLE, BUSY.
- IDLE with start=1 and mdOp in 0..3:
  - Compute the result at that edge into internal tmpHi/tmpLo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 from the next cycle.
- BUSY: counter decrements each cycle. The edge where counter==1:
  - Commits hi<=tmpHi, lo<=tmpLo.
  - Returns to IDLE; busy=0 in the following cycle.
- Latency: busy stays high for exactly N cycles after the issue cycle. New HI/LO are visible in the cycle busy first reads 0.
- IDLE with start=1, mdOp=4: hi<=srcA next edge. mdOp=5: lo<=srcA. No busy.
- start with mdOp 6/7: ignored.
- start while busy=1: ignored, state untouched. The hazard unit guarantees this never happens; it is a simulation assertion.
- Arithmetic:
  - MULT: signed 32x32 -> 64 bits; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 -> 64 bits.
  - DIV: signed, truncation toward zero; lo=quotient, hi=remainder (remainder takes the sign of the dividend).
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Division by zero (DIV or DIVU): the unit still goes busy for DIV_CYCLES, then leaves hi/lo unchanged.
- Operands are sampled only at the issue edge; later changes on srcA/srcB have no effect.
- hi/lo are direct register outputs, with no bypass of in-flight results.

Optional Feature:
- MD_TRACE_EN defined:
  - Every HI/LO commit prints "@<pc>: $hi <= <value>" and/or "@<pc>: $lo <= <value>" in %h format.
  - <pc> is the pcIn latched at issue.
  - MT ops print only the register they write.
  - pcIn is latched at issue.
- MD_TRACE_EN undefined: no $display; pcIn is unused and no register is spent latching it. Functional behaviour is identical.

Decomposition:
- Shared package md_pkg holds:
  - mdOp encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Default cycle constants.
  - The state enum (IDLE/BUSY).
- Single module; no sub-module is natural, since arithmetic uses behavioural operators and only counter/state control remains.

Test Plan:
- Reset behaviour: after reset release, hi=0, lo=0, busy=0. Issue MULT srcA=0xFFFFFFFF srcB=0x00000002 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Unsigned multiply: MULTU same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Division by zero: set state via MTHI 0x1234 and MTLO 0x5678 (no busy, values visible next cycle); then DIVU by 0 -> busy 10 cycles, hi/lo remain 0x1234/0x5678. Overflow: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start while busy: start MULT while busy -> ignored, first result committed unchanged. Operand change mid-op has no effect.
- Reset mid-operation: drive reset=0 at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately, without waiting for clk, and no later commit occurs.
